lsu_stage: RTL and testbench

- Load/store unit directly downstream of the ALU in the RV64 core.
- Takes the ALU-computed effective address plus store data and funct3.
- Issues one aligned 64-bit memory transaction over a valid/ready request channel and waits for the response.
- Returns sign/zero-extended load data, or a store acknowledge, to writeback. Flags misaligned or illegal accesses without touching memory.

---
 rtl/lsu_stage.sv | 173 +++++++++++++++++
 tb/tb_lsu_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Single-outstanding load/store unit behind the ALU: one aligned 64-bit memory
// transaction per instruction, with byte-lane steering and load extension.
module lsu_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [4:0]        out_rd,
    output logic              out_we,
    output logic              out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    logic       is_store_q;
    logic [2:0] funct3_q;
    logic [2:0] off_q;
    logic [2:0] in_off;

    assign in_off   = in_addr[2:0];
    assign in_ready = (state == IDLE);

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [2:0] off);
        logic ok;
        ok = is_store ? !f3[2] : (f3 != 3'b111);
        case (f3[1:0])
            2'd1:    ok = ok && (off[0] == 1'b0);
            2'd2:    ok = ok && (off[1:0] == 2'b00);
            2'd3:    ok = ok && (off == 3'b000);
            default: ok = ok;
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Truncate before shifting so lanes outside the mask carry zeros.
    function automatic logic [XLEN-1:0] lane_wdata(input logic [1:0] size, input logic [2:0] off,
                                                   input logic [XLEN-1:0] data);
        logic [XLEN-1:0] sized;
        case (size)
            2'd0:    sized = {{(XLEN-8){1'b0}}, data[7:0]};
            2'd1:    sized = {{(XLEN-16){1'b0}}, data[15:0]};
            2'd2:    sized = {{(XLEN-32){1'b0}}, data[31:0]};
            default: sized = data;
        endcase
        return sized << {off, 3'b000};
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [2:0] off,
                                                     input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] lane;
        logic [XLEN-1:0] res;
        lane = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  res = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  res = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b100:  res = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  res = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  res = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: res = lane;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'b000;
            off_q         <= 3'b000;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_we    <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= 8'h00;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_rd        <= 5'd0;
            out_we        <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_store_q <= in_is_store;
                        funct3_q   <= in_funct3;
                        off_q      <= in_off;
                        out_rd     <= in_rd;
                        if (access_legal(in_is_store, in_funct3, in_off)) begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
                            mem_req_we    <= in_is_store;
                            mem_req_wmask <= in_is_store ? lane_mask(in_funct3[1:0], in_off) : 8'h00;
                            mem_req_wdata <= in_is_store ?
                                             lane_wdata(in_funct3[1:0], in_off, in_wdata) : '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_err   <= 1'b1;
                            out_we    <= 1'b0;
                            out_data  <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        mem_req_we    <= 1'b0;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= 8'h00;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_we    <= !is_store_q;
                        out_data  <= is_store_q ? '0 : load_extract(funct3_q, off_q, mem_rsp_rdata);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_rd    <= 5'd0;
                        out_we    <= 1'b0;
                        out_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Scoreboard bench for lsu_stage: a byte-level reference model predicts memory
// requests and writeback results; a memory responder and a writeback monitor check them.
module tb_lsu_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_err;

    lsu_stage #(.XLEN(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .out_err(out_err)
    );

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
        int          stall;
        int          delay;
    } req_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        err;
        int          ostall;
    } out_t;

    req_t req_q[$];
    out_t out_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-by-byte view of the RISC-V load/store rules.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input bit st, input logic [2:0] f3, input int off);
        if (st && f3[2]) return 1'b0;
        if (!st && f3 == 3'b111) return 1'b0;
        return (off % nbytes(f3)) == 0;
    endfunction

    function automatic logic [7:0] model_mask(input logic [2:0] f3, input int off);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + nbytes(f3)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [2:0] f3, input int off,
                                                input logic [63:0] wd);
        logic [63:0] r;
        r = 64'd0;
        for (int b = 0; b < nbytes(f3); b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input int off,
                                               input logic [63:0] rd);
        logic [63:0] r;
        int          n;
        n = nbytes(f3);
        r = 64'd0;
        for (int b = 0; b < n; b++) r[8*b +: 8] = rd[8*(off+b) +: 8];
        if (!f3[2] && n < 8 && r[8*n-1])
            for (int b = n; b < 8; b++) r[8*b +: 8] = 8'hFF;
        return r;
    endfunction

    // Memory responder: checks each request against the model and answers it.
    req_t mcur;
    bit   mbusy = 1'b0;
    bit   mpend = 1'b0;
    int   mscnt = 0;
    int   mpcnt = 0;
    logic [63:0] mprdata = 64'd0;

    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = 64'd0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (mpend) begin
                if (mpcnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = mprdata;
                    mpend = 1'b0;
                end else begin
                    mpcnt--;
                end
            end
            if (mem_req_valid) begin
                if (!mbusy) begin
                    chk("req_expected", 64'(req_q.size() != 0), 64'd1);
                    if (req_q.size() != 0) mcur = req_q.pop_front();
                    else mcur = '{64'd0, 1'b0, 64'd0, 8'h00, 64'd0, 0, 0};
                    mbusy = 1'b1;
                    mscnt = mcur.stall;
                end
                chk("req_addr", mem_req_addr, mcur.addr);
                chk("req_we", 64'(mem_req_we), 64'(mcur.we));
                if (mcur.we) begin
                    chk("req_wmask", 64'(mem_req_wmask), 64'(mcur.wmask));
                    chk("req_wdata", mem_req_wdata, mcur.wdata);
                end
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                if (mscnt > 0) begin
                    mem_req_ready = 1'b0;
                    mscnt--;
                end else begin
                    mem_req_ready = 1'b1;
                    mbusy   = 1'b0;
                    mpend   = 1'b1;
                    mpcnt   = mcur.delay;
                    mprdata = mcur.rdata;
                end
            end else begin
                if (mbusy) begin
                    chk("req_valid_held", 64'(mem_req_valid), 64'd1);
                    mbusy = 1'b0;
                end
                mem_req_ready = 1'b0;
            end
        end
    end

    // Writeback monitor: compares every presented result with the scoreboard.
    out_t ocur;
    bit   ohave = 1'b0;
    int   ocnt  = 0;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (!ohave) begin
                    chk("out_expected", 64'(out_q.size() != 0), 64'd1);
                    if (out_q.size() != 0) ocur = out_q.pop_front();
                    else ocur = '{64'd0, 5'd0, 1'b0, 1'b0, 0};
                    ohave = 1'b1;
                    ocnt  = ocur.ostall;
                end
                chk("out_data", out_data, ocur.data);
                chk("out_rd", 64'(out_rd), 64'(ocur.rd));
                chk("out_we", 64'(out_we), 64'(ocur.we));
                chk("out_err", 64'(out_err), 64'(ocur.err));
                chk("in_ready_done", 64'(in_ready), 64'd0);
                chk("req_valid_done", 64'(mem_req_valid), 64'd0);
                if (ocnt > 0) begin
                    out_ready = 1'b0;
                    ocnt--;
                end else begin
                    out_ready = 1'b1;
                    ohave = 1'b0;
                end
            end else begin
                if (ohave) begin
                    chk("out_valid_held", 64'(out_valid), 64'd1);
                    ohave = 1'b0;
                end
                out_ready = 1'b0;
            end
        end
    end

    task automatic check_idle(input string tag);
        #1;
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_req_we"}, 64'(mem_req_we), 64'd0);
        chk({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'd0);
        chk({tag, "_req_wdata"}, mem_req_wdata, 64'd0);
        chk({tag, "_req_addr"}, mem_req_addr, 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
        chk({tag, "_out_we"}, 64'(out_we), 64'd0);
        chk({tag, "_out_err"}, 64'(out_err), 64'd0);
    endtask

    // Issue one instruction; lat >= 0 also checks cycles from acceptance to out_valid.
    task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [4:0] rd, input logic [63:0] rdata,
                         input int stall, input int delay, input int ostall, input int lat,
                         input bit no_out);
        int   off;
        bit   ok;
        int   n;
        req_t r;
        out_t o;
        off = int'(addr[2:0]);
        ok  = model_legal(st, f3, off);
        if (ok) begin
            r.addr  = {addr[63:3], 3'b000};
            r.we    = st;
            r.wdata = st ? model_wdata(f3, off, wd) : 64'd0;
            r.wmask = st ? model_mask(f3, off) : 8'h00;
            r.rdata = rdata;
            r.stall = stall;
            r.delay = delay;
            req_q.push_back(r);
        end
        o.data   = (ok && !st) ? model_load(f3, off, rdata) : 64'd0;
        o.rd     = rd;
        o.we     = ok && !st;
        o.err    = !ok;
        o.ostall = ostall;
        if (!no_out) out_q.push_back(o);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wd;
        in_rd       = rd;
        @(negedge clk);
        in_valid = 1'b0;
        in_addr  = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom};
        if (lat >= 0) begin
            n = 1;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("latency", 64'(n), 64'(lat));
        end
    endtask

    localparam logic [63:0] RDATA = 64'h8765_4321_DEAD_BEEF;

    initial begin
        int          n;
        bit          st;
        logic [2:0]  f3;
        logic [2:0]  off;
        logic [63:0] a;

        rst         = 1'b1;
        in_valid    = 1'b0;
        in_is_store = 1'b0;
        in_funct3   = 3'b000;
        in_addr     = 64'd0;
        in_wdata    = 64'd0;
        in_rd       = 5'd0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 3'b010, 64'h8000_0004, 64'd0, 5'd1, RDATA, 0, 0, 0, 3, 1'b0);
        issue(1'b0, 3'b100, 64'h8000_0007, 64'd0, 5'd2, RDATA, 0, 0, 0, 3, 1'b0);
        issue(1'b0, 3'b000, 64'h8000_0007, 64'd0, 5'd3, RDATA, 0, 0, 0, 3, 1'b0);
        issue(1'b1, 3'b001, 64'h8000_0006, 64'h1234, 5'd4, 64'd0, 0, 0, 0, 3, 1'b0);
        issue(1'b0, 3'b011, 64'h8000_0004, 64'd0, 5'd5, RDATA, 0, 0, 0, 1, 1'b0);
        issue(1'b0, 3'b111, 64'h8000_0000, 64'd0, 5'd6, RDATA, 0, 0, 0, 1, 1'b0);
        issue(1'b1, 3'b100, 64'h8000_0000, 64'hFF, 5'd7, 64'd0, 0, 0, 0, 1, 1'b0);
        issue(1'b1, 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 5'd8, 64'd0, 3, 1, 2, -1, 1'b0);
        issue(1'b0, 3'b101, 64'h8000_0012, 64'd0, 5'd9, RDATA, 3, 2, 2, -1, 1'b0);

        // Reset while waiting for the response; the late response must be ignored.
        issue(1'b0, 3'b011, 64'h8000_0020, 64'd0, 5'd10, RDATA, 2, 6, 0, -1, 1'b1);
        n = 0;
        while (mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        check_idle("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_release");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_out_after_rst", 64'(out_valid), 64'd0);
            chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        end
        issue(1'b0, 3'b011, 64'h8000_0008, 64'd0, 5'd11, 64'hCAFE_F00D_1234_5678, 0, 0, 0, 3, 1'b0);

        for (int t = 0; t < 150; t++) begin
            st  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            off = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) off = off & ~3'(nbytes(f3) - 1);
            a = {$urandom, $urandom};
            a[2:0] = off;
            issue(st, f3, a, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                  {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), -1, 1'b0);
        end

        n = 0;
        while ((out_q.size() != 0 || req_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_out_q", 64'(out_q.size()), 64'd0);
        chk("drain_req_q", 64'(req_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
